circular_queue_mw1r: RTL and testbench

- In-order issue queue: multi-lane enqueue from dispatch, single in-order dequeue to the functional unit.
- Each entry carries a payload with an embedded ROB id plus per-entry condition bits. Condition bits are updated by ROB-id match from writeback ports.
- The head entry dequeues only when all of its condition bits are set.
- A rollback flush squashes all entries younger than a given ROB id by pulling the tail pointer back.

---
 rtl/circular_queue_mw1r.sv | 140 ++++++++++++++
 tb/tb_circular_queue_mw1r.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circular_queue_mw1r.sv
// In-order issue queue: multi-lane enqueue, single in-order dequeue gated on per-entry condition bits,
// condition updates by ROB-id match, and rollback flush that pulls the tail back over younger entries.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high; enq_ready never depends on enq_valid, deq_valid never depends on deq_ready.
module circular_queue_mw1r #(
    parameter int DEPTH           = 8,
    parameter int DATA_WIDTH      = 248,
    parameter int CONDITION_WIDTH = 2,
    parameter int ENQ_LANES       = 2,
    parameter int UPD_PORTS       = 2,
    parameter int ROBID_WIDTH     = 7,
    parameter int ROBID_LSB       = 241
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [ENQ_LANES-1:0]                 enq_valid,
    output logic                                 enq_ready,
    input  logic [ENQ_LANES*DATA_WIDTH-1:0]      enq_data,
    input  logic [ENQ_LANES*CONDITION_WIDTH-1:0] enq_condition,
    output logic                                 deq_valid,
    input  logic                                 deq_ready,
    output logic [DATA_WIDTH-1:0]                deq_data,
    output logic [CONDITION_WIDTH-1:0]           deq_condition,
    input  logic                                 flush_valid,
    input  logic [ROBID_WIDTH-1:0]               flush_robid,
    input  logic [UPD_PORTS-1:0]                 upd_valid,
    input  logic [UPD_PORTS*ROBID_WIDTH-1:0]     upd_robid,
    input  logic [UPD_PORTS*CONDITION_WIDTH-1:0] upd_data,
    output logic [$clog2(DEPTH):0]               count,
    output logic                                 full,
    output logic                                 empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0]      data_q [DEPTH];
    logic [CONDITION_WIDTH-1:0] cond_q [DEPTH];
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [PW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q;
    logic [DEPTH-1:0]           squash;
    logic [CW-1:0]              n_squash, n_enq;
    logic                       enq_fire, deq_fire;

    // Wrap-bit age compare: x is younger than f. Equal ids are not younger.
    function automatic logic is_younger(input logic [ROBID_WIDTH-1:0] x, input logic [ROBID_WIDTH-1:0] f);
        return (x[ROBID_WIDTH-1] != f[ROBID_WIDTH-1]) ^ (x[ROBID_WIDTH-2:0] > f[ROBID_WIDTH-2:0]);
    endfunction

    always_comb begin
        squash   = '0;
        n_squash = '0;
        for (int e = 0; e < DEPTH; e++) begin
            squash[e] = valid_q[e] && is_younger(data_q[e][ROBID_LSB +: ROBID_WIDTH], flush_robid);
            n_squash  = n_squash + CW'(squash[e]);
        end
    end

    always_comb begin
        n_enq = '0;
        for (int k = 0; k < ENQ_LANES; k++) begin
            n_enq = n_enq + CW'(enq_valid[k]);
        end
    end

    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign count         = count_q;
    assign enq_ready     = ((CW'(DEPTH) - count_q) >= CW'(ENQ_LANES)) && !flush_valid;
    assign deq_valid     = !empty && (&cond_q[head_q]) && !flush_valid;
    assign deq_data      = data_q[head_q];
    assign deq_condition = cond_q[head_q];
    assign enq_fire      = enq_ready && (|enq_valid);
    assign deq_fire      = deq_valid && deq_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush_valid) begin
            valid_d = valid_q & ~squash;
        end else begin
            if (deq_fire) valid_d[head_q] = 1'b0;
            if (enq_fire) begin
                for (int k = 0; k < ENQ_LANES; k++) begin
                    if (enq_valid[k]) valid_d[tail_q + PW'(k)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (flush_valid) begin
                tail_q  <= tail_q - n_squash[PW-1:0];
                count_q <= count_q - n_squash;
            end else begin
                head_q  <= head_q + PW'(deq_fire);
                tail_q  <= tail_q + (enq_fire ? n_enq[PW-1:0] : '0);
                count_q <= count_q + (enq_fire ? n_enq : '0) - CW'(deq_fire);
            end
        end
    end

    // Payload storage is not reset; valid_q alone decides which slots are live.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [DATA_WIDTH-1:0]      data_r, data_d;
        logic [CONDITION_WIDTH-1:0] cond_r, cond_d;

        always_comb begin
            data_d = data_r;
            cond_d = cond_r;
            for (int p = 0; p < UPD_PORTS; p++) begin
                if (upd_valid[p] && valid_q[e] &&
                    data_r[ROBID_LSB +: ROBID_WIDTH] == upd_robid[p*ROBID_WIDTH +: ROBID_WIDTH])
                    cond_d = upd_data[p*CONDITION_WIDTH +: CONDITION_WIDTH];
            end
            // A fresh enqueue into this slot overrides any same-cycle update.
            if (enq_fire) begin
                for (int k = 0; k < ENQ_LANES; k++) begin
                    if (enq_valid[k] && (tail_q + PW'(k)) == PW'(e)) begin
                        data_d = enq_data[k*DATA_WIDTH +: DATA_WIDTH];
                        cond_d = enq_condition[k*CONDITION_WIDTH +: CONDITION_WIDTH];
                    end
                end
            end
        end

        always_ff @(posedge clock) begin
            data_r <= data_d;
            cond_r <= cond_d;
        end

        assign data_q[e] = data_r;
        assign cond_q[e] = cond_r;
    end
endmodule

// File: tb/tb_circular_queue_mw1r.sv
// Bench for circular_queue_mw1r: directed scenarios plus randomized traffic, checked against an
// ordered-list reference model of the surviving entries.
module tb_circular_queue_mw1r;
    localparam int DEPTH = 8;
    localparam int DW    = 248;
    localparam int CDW   = 2;
    localparam int LANES = 2;
    localparam int UPD   = 2;
    localparam int RW    = 7;
    localparam int RLSB  = 241;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [LANES-1:0]       enq_valid;
    logic                   enq_ready;
    logic [LANES*DW-1:0]    enq_data;
    logic [LANES*CDW-1:0]   enq_condition;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [DW-1:0]          deq_data;
    logic [CDW-1:0]         deq_condition;
    logic                   flush_valid;
    logic [RW-1:0]          flush_robid;
    logic [UPD-1:0]         upd_valid;
    logic [UPD*RW-1:0]      upd_robid;
    logic [UPD*CDW-1:0]     upd_data;
    logic [CNTW-1:0]        count;
    logic                   full;
    logic                   empty;

    logic [DW-1:0]  exp_q[$];
    logic [CDW-1:0] exp_cond_q[$];
    logic [RW-1:0]  next_id;
    int             n_checks = 0;
    int             n_errors = 0;

    circular_queue_mw1r #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .CONDITION_WIDTH(CDW), .ENQ_LANES(LANES),
        .UPD_PORTS(UPD), .ROBID_WIDTH(RW), .ROBID_LSB(RLSB)
    ) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_condition(enq_condition),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_condition(deq_condition),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .upd_valid(upd_valid), .upd_robid(upd_robid), .upd_data(upd_data),
        .count(count), .full(full), .empty(empty)
    );

    // Clock / reset
    always #5 clock = ~clock;

    function automatic logic [RW-1:0] robid_of(input logic [DW-1:0] p);
        return p[RLSB +: RW];
    endfunction

    // x is younger than f when it lies 1..2^(RW-1) steps ahead of f, modulo 2^RW.
    function automatic bit younger(input logic [RW-1:0] x, input logic [RW-1:0] f);
        int unsigned d;
        d = (int'(x) - int'(f)) & ((1 << RW) - 1);
        return (d >= 1) && (d <= (1 << (RW - 1)));
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic idle();
        enq_valid   = '0;
        flush_valid = 1'b0;
        upd_valid   = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic put_lane(input int k, input logic [CDW-1:0] c);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        w[RLSB +: RW] = next_id;
        enq_valid[k]                = 1'b1;
        enq_data[k*DW +: DW]        = w[DW-1:0];
        enq_condition[k*CDW +: CDW] = c;
        next_id                     = next_id + 1'b1;
    endtask

    task automatic set_upd(input int p, input logic [RW-1:0] id, input logic [CDW-1:0] d);
        upd_valid[p]             = 1'b1;
        upd_robid[p*RW +: RW]    = id;
        upd_data[p*CDW +: CDW]   = d;
    endtask

    // Monitor + reference model: compare outputs against the pre-edge model, then apply this cycle's inputs.
    always @(negedge clock) begin
        int             sz;
        bit             exp_dv;
        bit             room;
        logic [DW-1:0]  nd[$];
        logic [CDW-1:0] nc[$];
        if (reset) begin
            exp_q.delete();
            exp_cond_q.delete();
        end else begin
            sz     = exp_q.size();
            room   = (DEPTH - sz) >= LANES;
            exp_dv = (sz > 0) && !flush_valid;
            if (sz > 0) exp_dv = exp_dv && (&exp_cond_q[0]);
            check("deq_valid", deq_valid, exp_dv);
            if (exp_dv) begin
                check("deq_data", deq_data, exp_q[0]);
                check("deq_condition", deq_condition, exp_cond_q[0]);
            end
            check("count", count, sz);
            check("full", full, sz == DEPTH);
            check("empty", empty, sz == 0);
            check("enq_ready", enq_ready, room && !flush_valid);
            assert ((enq_valid & (enq_valid + 1'b1)) == '0) else $error("enq_valid not packed from lane 0");
            assert (enq_valid == '0 || flush_valid || room) else $error("enq_valid driven while queue lacks room");

            for (int i = 0; i < sz; i++)
                for (int p = 0; p < UPD; p++)
                    if (upd_valid[p] && robid_of(exp_q[i]) == upd_robid[p*RW +: RW])
                        exp_cond_q[i] = upd_data[p*CDW +: CDW];

            if (flush_valid) begin
                nd.delete();
                nc.delete();
                for (int i = 0; i < sz; i++) begin
                    if (!younger(robid_of(exp_q[i]), flush_robid)) begin
                        nd.push_back(exp_q[i]);
                        nc.push_back(exp_cond_q[i]);
                    end
                end
                exp_q      = nd;
                exp_cond_q = nc;
            end else begin
                if (exp_dv && deq_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_cond_q.pop_front());
                end
                if (enq_valid != '0 && room) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (enq_valid[k]) begin
                            exp_q.push_back(enq_data[k*DW +: DW]);
                            exp_cond_q.push_back(enq_condition[k*CDW +: CDW]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int sz;
        int n;
        logic [RW-1:0]  id;
        logic [CDW-1:0] d;
        idle();
        deq_ready     = 1'b0;
        flush_robid   = '0;
        upd_robid     = '0;
        upd_data      = '0;
        enq_data      = '0;
        enq_condition = '0;
        next_id       = '0;
        reset         = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("rst_deq_valid", deq_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_enq_ready", enq_ready, 1'b1);
        check("rst_count", count, 0);

        // Two-lane enqueue then drain
        next_id = 7'd0;
        put_lane(0, 2'b11); put_lane(1, 2'b11);
        step();
        check("two_count", count, 2);
        check("two_deq_valid", deq_valid, 1'b1);
        check("two_head_id", robid_of(deq_data), 7'd0);
        deq_ready = 1'b1;
        step(); step();
        deq_ready = 1'b0;
        check("two_empty", empty, 1'b1);

        // Fill to full, then multi-port update on the head
        next_id = 7'd3;
        put_lane(0, 2'b01); put_lane(1, 2'b00); step();
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        check("fill6_count", count, 6);
        check("fill6_enq_ready", enq_ready, 1'b1);
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        check("fill_count", count, 8);
        check("fill_full", full, 1'b1);
        check("fill_enq_ready", enq_ready, 1'b0);
        check("fill_deq_valid", deq_valid, 1'b0);
        set_upd(0, 7'd3, 2'b10); set_upd(1, 7'd3, 2'b11);
        step();
        check("upd_deq_valid", deq_valid, 1'b1);
        check("upd_cond", deq_condition, 2'b11);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("c7_count", count, 7);
        check("c7_enq_ready", enq_ready, 1'b0);
        check("c7_full", full, 1'b0);

        // Flush across the ROB-id wrap
        reset = 1'b1; step(); reset = 1'b0;
        check("wrap_rst_count", count, 0);
        next_id = 7'h3E;
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        check("wrap_count4", count, 4);
        flush_valid = 1'b1; flush_robid = 7'h3F;
        step();
        check("wrap_flush_count", count, 2);
        next_id = 7'h40;
        put_lane(0, 2'b11); put_lane(1, 2'b11); step();
        check("wrap_refill_count", count, 4);
        set_upd(0, 7'h3E, 2'b11); set_upd(1, 7'h3F, 2'b11);
        deq_ready = 1'b1;
        step();
        repeat (4) step();
        deq_ready = 1'b0;
        check("wrap_drained", empty, 1'b1);

        // Flush blocks a concurrent enqueue and dequeue
        put_lane(0, 2'b11); put_lane(1, 2'b11); step();
        check("fe_deq_valid_pre", deq_valid, 1'b1);
        flush_valid = 1'b1; flush_robid = 7'h42;
        put_lane(0, 2'b11); put_lane(1, 2'b11);
        deq_ready = 1'b1;
        #1;
        check("fe_enq_ready", enq_ready, 1'b0);
        check("fe_deq_valid", deq_valid, 1'b0);
        step();
        next_id = 7'h43;
        check("fe_count", count, 1);
        check("fe_deq_valid_post", deq_valid, 1'b1);
        step();
        deq_ready = 1'b0;
        check("fe_empty", empty, 1'b1);

        // Reset mid-operation
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        put_lane(0, 2'b00); put_lane(1, 2'b00); step();
        put_lane(0, 2'b00); step();
        check("mid_count5", count, 5);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_deq_valid", deq_valid, 1'b0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sz        = exp_q.size();
            deq_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                flush_valid = 1'b1;
                flush_robid = next_id - 7'd1 - RW'($urandom_range(0, 9));
                next_id     = flush_robid + 7'd1;
            end else if ((DEPTH - sz) >= LANES && $urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, LANES);
                for (int k = 0; k < n; k++) put_lane(k, CDW'($urandom_range(0, 3)));
            end
            for (int p = 0; p < UPD; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    id = (sz > 0) ? robid_of(exp_q[$urandom_range(0, sz - 1)]) : RW'($urandom);
                    d  = ($urandom_range(0, 1) == 1) ? 2'b11 : CDW'($urandom_range(0, 3));
                    set_upd(p, id, d);
                end
            end
            step();
        end
        deq_ready = 1'b0;
        step();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
